// File: rtl/pll_cfg_pkg.sv
// rtl/pll_cfg_pkg.sv - shared constants, state type and write-data helpers for pll_cfg_ctrl
package pll_cfg_pkg;

    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_START = 6'd2;
    localparam logic [5:0] ADDR_N     = 6'd3;
    localparam logic [5:0] ADDR_M     = 6'd4;
    localparam logic [5:0] ADDR_C     = 6'd5;
    localparam logic [5:0] ADDR_K     = 6'd7;

    // Counter word layout: {odd, bypass, high[7:0], low[7:0]}
    localparam int FLD_LO_LSB  = 0;
    localparam int FLD_HI_LSB  = 8;
    localparam int FLD_BYPASS  = 16;
    localparam int FLD_ODD     = 17;
    localparam int CW_W        = FLD_ODD + 1;
    localparam int C_SEL_SHIFT = 18;

    localparam int LOCK_STABLE = 4;

    typedef enum logic [3:0] {
        IDLE,
        WR_MODE,
        WR_N,
        WR_M,
        WR_K,
        WR_C,
        WR_START,
        SETTLE,
        WAIT_LOCK,
        DONE
    } state_t;

    function automatic logic [31:0] cnt_wr_data(input logic [CW_W-1:0] word);
        return {14'b0, word};
    endfunction

    function automatic logic [31:0] c_wr_data(input logic [1:0] sel, input logic [CW_W-1:0] word);
        return cnt_wr_data(word) | (32'(sel) << C_SEL_SHIFT);
    endfunction

endpackage

// File: rtl/pll_cfg_sync.sv
// rtl/pll_cfg_sync.sv - two-flop synchronizer for the asynchronous PLL lock indication
module pll_cfg_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_cfg_ctrl.sv
// rtl/pll_cfg_ctrl.sv - PLL reconfiguration master; PLL_CFG_FRAC_EN adds the fractional-K write
module pll_cfg_ctrl
    import pll_cfg_pkg::*;
#(
    parameter int LOCK_TIMEOUT  = 1000000,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [17:0]      cfg_n,
    input  logic [17:0]      cfg_m,
    input  logic [31:0]      cfg_k,
    input  logic [17:0]      cfg_c0,
    input  logic [17:0]      cfg_c1,
    input  logic [17:0]      cfg_c2,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [5:0]       mgmt_address,
    output logic [31:0]      mgmt_writedata,
    output logic             mgmt_write,
    output logic             mgmt_read,
    input  logic             mgmt_waitrequest,
    input  logic             pll_locked
);

    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    state_t          state;
    logic [17:0]     n_sh, m_sh, c0_sh, c1_sh, c2_sh;
    logic [1:0]      cidx;
    logic [TW-1:0]   tcnt;
    logic [TW-1:0]   tcnt_inc;
    logic [SW-1:0]   scnt;
    logic [2:0]      lcnt;
    logic            lock_s;

`ifdef PLL_CFG_FRAC_EN
    logic [31:0]     k_sh;
`else
    logic            unused_k;
    assign unused_k = ^cfg_k;
`endif

    assign mgmt_read = 1'b0;

    pll_cfg_sync u_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // Saturating: a very long lock wait must never wrap back into range
    assign tcnt_inc = (tcnt == TW'(LOCK_TIMEOUT)) ? tcnt : tcnt + TW'(1);

    always_ff @(posedge refclk) begin
        if (rst) begin
            state          <= IDLE;
            cfg_busy       <= 1'b0;
            cfg_done       <= 1'b0;
            cfg_err        <= 1'b0;
            mgmt_write     <= 1'b0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
            n_sh           <= '0;
            m_sh           <= '0;
            c0_sh          <= '0;
            c1_sh          <= '0;
            c2_sh          <= '0;
`ifdef PLL_CFG_FRAC_EN
            k_sh           <= '0;
`endif
            cidx           <= '0;
            tcnt           <= '0;
            scnt           <= '0;
            lcnt           <= '0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE: if (cfg_start) begin
                    n_sh           <= cfg_n;
                    m_sh           <= cfg_m;
                    c0_sh          <= cfg_c0;
                    c1_sh          <= cfg_c1;
                    c2_sh          <= cfg_c2;
`ifdef PLL_CFG_FRAC_EN
                    k_sh           <= cfg_k;
`endif
                    state          <= WR_MODE;
                    cfg_busy       <= 1'b1;
                    cfg_err        <= 1'b0;
                    mgmt_write     <= 1'b1;
                    mgmt_address   <= ADDR_MODE;
                    mgmt_writedata <= 32'd0;
                end
                WR_MODE: if (!mgmt_waitrequest) begin
                    state          <= WR_N;
                    mgmt_address   <= ADDR_N;
                    mgmt_writedata <= cnt_wr_data(n_sh);
                end
                WR_N: if (!mgmt_waitrequest) begin
                    state          <= WR_M;
                    mgmt_address   <= ADDR_M;
                    mgmt_writedata <= cnt_wr_data(m_sh);
                end
`ifdef PLL_CFG_FRAC_EN
                WR_M: if (!mgmt_waitrequest) begin
                    state          <= WR_K;
                    mgmt_address   <= ADDR_K;
                    mgmt_writedata <= k_sh;
                end
                WR_K: if (!mgmt_waitrequest) begin
                    state          <= WR_C;
                    cidx           <= 2'd0;
                    mgmt_address   <= ADDR_C;
                    mgmt_writedata <= c_wr_data(2'd0, c0_sh);
                end
`else
                WR_M: if (!mgmt_waitrequest) begin
                    state          <= WR_C;
                    cidx           <= 2'd0;
                    mgmt_address   <= ADDR_C;
                    mgmt_writedata <= c_wr_data(2'd0, c0_sh);
                end
`endif
                WR_C: if (!mgmt_waitrequest) begin
                    case (cidx)
                        2'd0: begin
                            cidx           <= 2'd1;
                            mgmt_writedata <= c_wr_data(2'd1, c1_sh);
                        end
                        2'd1: begin
                            cidx           <= 2'd2;
                            mgmt_writedata <= c_wr_data(2'd2, c2_sh);
                        end
                        default: begin
                            state          <= WR_START;
                            mgmt_address   <= ADDR_START;
                            mgmt_writedata <= 32'd1;
                        end
                    endcase
                end
                // Both counters include the completion cycle itself, so they read "cycles elapsed"
                WR_START: if (!mgmt_waitrequest) begin
                    state          <= SETTLE;
                    mgmt_write     <= 1'b0;
                    mgmt_address   <= '0;
                    mgmt_writedata <= '0;
                    tcnt           <= TW'(1);
                    scnt           <= SW'(1);
                    lcnt           <= '0;
                end
                SETTLE: begin
                    tcnt <= tcnt_inc;
                    if (scnt == SW'(SETTLE_CYCLES)) state <= WAIT_LOCK;
                    else                             scnt  <= scnt + SW'(1);
                end
                WAIT_LOCK: begin
                    tcnt <= tcnt_inc;
                    if (lock_s && lcnt == 3'(LOCK_STABLE - 1)) begin
                        state    <= DONE;
                        cfg_done <= 1'b1;
                        cfg_busy <= 1'b0;
                        cfg_err  <= 1'b0;
                    end else if (tcnt_inc == TW'(LOCK_TIMEOUT)) begin
                        state    <= DONE;
                        cfg_done <= 1'b1;
                        cfg_busy <= 1'b0;
                        cfg_err  <= 1'b1;
                    end else begin
                        lcnt <= lock_s ? lcnt + 3'd1 : 3'd0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_cfg_ctrl.sv
// tb/tb_pll_cfg_ctrl.sv - self-checking bench for pll_cfg_ctrl
module tb_pll_cfg_ctrl;

    localparam int LT = 100;
    localparam int ST = 8;

    logic        refclk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [17:0] cfg_n = '0, cfg_m = '0, cfg_c0 = '0, cfg_c1 = '0, cfg_c2 = '0;
    logic [31:0] cfg_k = '0;
    logic        cfg_busy, cfg_done, cfg_err;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_write, mgmt_read;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b0;

    pll_cfg_ctrl #(.LOCK_TIMEOUT(LT), .SETTLE_CYCLES(ST)) dut (
        .refclk           (refclk),
        .rst              (rst),
        .cfg_start        (cfg_start),
        .cfg_n            (cfg_n),
        .cfg_m            (cfg_m),
        .cfg_k            (cfg_k),
        .cfg_c0           (cfg_c0),
        .cfg_c1           (cfg_c1),
        .cfg_c2           (cfg_c2),
        .cfg_busy         (cfg_busy),
        .cfg_done         (cfg_done),
        .cfg_err          (cfg_err),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_write       (mgmt_write),
        .mgmt_read        (mgmt_read),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_locked       (pll_locked)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic [17:0] n, m, c0, c1, c2;
        logic [31:0] k;
        int          stall;
        int          lock_delay;
        bit          glitch;
        bit          poke;
        logic        exp_err;
    } vec_t;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int c0 = -1;
    int stall_n = 0;
    int hold_cnt = 0;
    int pres_len = 0;
    int stab_err = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    logic done_err, done_busy;
    logic [5:0]  prev_addr;
    logic [31:0] prev_data;
    logic [37:0] cap_q[$];
    logic [37:0] exp_q[$];
    int          len_q[$];
    vec_t        vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge refclk);
        #1;
    endtask

    // Slave model: stalls each write stall_n cycles, logs completed writes and hold lengths
    initial forever begin
        @(negedge refclk);
        cyc++;
        if (mgmt_write) begin
            if (pres_len > 0 && (mgmt_address !== prev_addr || mgmt_writedata !== prev_data))
                stab_err++;
            pres_len++;
            prev_addr = mgmt_address;
            prev_data = mgmt_writedata;
            if (hold_cnt < stall_n) begin
                mgmt_waitrequest = 1'b1;
                hold_cnt++;
            end else begin
                mgmt_waitrequest = 1'b0;
                hold_cnt = 0;
                cap_q.push_back({mgmt_address, mgmt_writedata});
                len_q.push_back(pres_len);
                pres_len = 0;
                if (mgmt_address == 6'd2) c0 = cyc;
            end
        end else begin
            mgmt_waitrequest = 1'b0;
            hold_cnt = 0;
            pres_len = 0;
        end
        if (cfg_done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_err  = cfg_err;
            done_busy = cfg_busy;
        end
    end

    task automatic build_exp(input vec_t v);
        logic [17:0] cw[3];
        cw[0] = v.c0; cw[1] = v.c1; cw[2] = v.c2;
        exp_q.delete();
        exp_q.push_back({6'd0, 32'd0});
        exp_q.push_back({6'd3, 32'(v.n)});
        exp_q.push_back({6'd4, 32'(v.m)});
`ifdef PLL_CFG_FRAC_EN
        exp_q.push_back({6'd7, v.k});
`endif
        for (int i = 0; i < 3; i++)
            exp_q.push_back({6'd5, 32'(cw[i]) + 32'(i) * 32'h40000});
        exp_q.push_back({6'd2, 32'd1});
    endtask

    task automatic run_seq(input vec_t v);
        int t;
        int exp_done;
        build_exp(v);
        stall_n = v.stall;
        cap_q.delete();
        len_q.delete();
        c0 = -1;
        done_cnt = 0;
        stab_err = 0;
        step();
        cfg_n = v.n; cfg_m = v.m; cfg_k = v.k;
        cfg_c0 = v.c0; cfg_c1 = v.c1; cfg_c2 = v.c2;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        check("busy_rise", cfg_busy, 1);
        check("err_clear_on_start", cfg_err, 0);
        check("first_write", {mgmt_write, mgmt_address, mgmt_writedata}, {1'b1, 6'd0, 32'd0});
        check("read_tied", mgmt_read, 0);
        if (v.poke) begin
            cfg_n = 18'($urandom); cfg_m = 18'($urandom); cfg_k = $urandom;
            cfg_c0 = 18'($urandom); cfg_c1 = 18'($urandom); cfg_c2 = 18'($urandom);
            step();
            step();
            cfg_start = 1'b1;
            step();
            cfg_start = 1'b0;
        end
        t = 0;
        while (c0 < 0 && t < 300) begin step(); t++; end
        check("start_write_seen", c0 >= 0, 1);
        if (c0 < 0) return;
        if (v.glitch) begin
            while (cyc < c0 + 15) step();
            pll_locked = 1'b1;
            step();
            step();
            pll_locked = 1'b0;
        end
        if (v.lock_delay >= 0) begin
            while (cyc < c0 + v.lock_delay) step();
            if (v.glitch) check("glitch_no_done", done_cnt, 0);
            pll_locked = 1'b1;
            exp_done = c0 + v.lock_delay + 2 + 4;
        end else begin
            exp_done = c0 + LT;
        end
        t = 0;
        while (done_cnt == 0 && t < 300) begin step(); t++; end
        check("done_cycle", done_cyc, exp_done);
        check("done_err", done_err, v.exp_err);
        check("busy_low_at_done", done_busy, 0);
        if (v.poke) cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        check("done_one_cycle", cfg_done, 0);
        step();
        check("start_in_done_ignored", {cfg_busy, mgmt_write}, 2'b00);
        check("err_sticky", cfg_err, v.exp_err);
        check("done_count", done_cnt, 1);
        pll_locked = 1'b0;
        check("write_count", cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check("write_addr_data", cap_q[i], exp_q[i]);
        for (int i = 0; i < len_q.size(); i++)
            check("write_hold_len", len_q[i], v.stall + 1);
        check("addr_data_stable", stab_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        vecs[0] = '{n:18'h20000, m:18'h00808, c0:18'h00202, c1:18'h00202, c2:18'h00202,
                    k:32'h80000000, stall:0, lock_delay:20, glitch:0, poke:0, exp_err:1'b0};
        vecs[1] = vecs[0];
        vecs[1].stall = 3;
        vecs[1].poke  = 1;
        vecs[2] = vecs[0];
        vecs[2].lock_delay = -1;
        vecs[2].exp_err    = 1'b1;
        vecs[2].poke       = 1;
        for (int i = 3; i < 8; i++) begin
            vecs[i].n  = 18'($urandom); vecs[i].m  = 18'($urandom);
            vecs[i].c0 = 18'($urandom); vecs[i].c1 = 18'($urandom);
            vecs[i].c2 = 18'($urandom); vecs[i].k  = $urandom;
            vecs[i].stall      = int'($urandom_range(0, 3));
            vecs[i].lock_delay = int'($urandom_range(10, 80));
            vecs[i].glitch     = 0;
            vecs[i].poke       = bit'($urandom_range(0, 1));
            vecs[i].exp_err    = 1'b0;
        end
        vecs[3].glitch     = 1;
        vecs[3].lock_delay = 50;

        // Reset with random inputs and a start request held high
        for (int i = 0; i < 3; i++) begin
            cfg_n = 18'($urandom); cfg_m = 18'($urandom); cfg_k = $urandom;
            cfg_start = 1'b1;
            pll_locked = 1'($urandom);
            step();
            check("reset_outputs",
                  {cfg_busy, cfg_done, cfg_err, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata},
                  41'd0);
        end
        rst = 1'b0;
        cfg_start = 1'b0;
        pll_locked = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("no_write_after_reset", cap_q.size(), 0);
        check("idle_after_reset", {cfg_busy, mgmt_write}, 2'b00);

        foreach (vecs[i]) begin
            run_seq(vecs[i]);
            step();
            step();
        end

        // Reset while the M write is on the bus abandons the sequence
        stall_n = 0;
        cap_q.delete();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        t = 0;
        while (!(mgmt_write && mgmt_address == 6'd4) && t < 50) begin step(); t++; end
        check("reached_wr_m", {mgmt_write, mgmt_address}, {1'b1, 6'd4});
        rst = 1'b1;
        step();
        check("rst_mid_write", mgmt_write, 0);
        check("rst_mid_busy", cfg_busy, 0);
        rst = 1'b0;
        cap_q.delete();
        for (int i = 0; i < 10; i++) step();
        check("no_write_after_abort", cap_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_cfg_ctrl.md
# pll_cfg_ctrl

Reconfiguration master for the system PLL. On request it programs new N, M, optional fractional-K and C0..C2 counter values through the Avalon-MM management port of the Altera PLL reconfiguration block. It then triggers the reconfiguration and waits for the PLL to relock, with a timeout. It sits between the memory-test control logic, which selects a test frequency, and the PLL reconfig IP, and runs on the 50 MHz reference clock.

## Interface
- `LOCK_TIMEOUT`, 1000000: max cycles from start-write completion to a stable lock (20 ms at 50 MHz).
- `SETTLE_CYCLES`, 8: cycles after the start-write during which `locked` is ignored.
- `refclk` in 1: sole clock. All logic is single clock.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_start` in 1: one-cycle request; accepted only in IDLE.
- `cfg_n` in 18: N word: [17] odd, [16] bypass, [15:8] high count, [7:0] low count.
- `cfg_m` in 18: M word, same layout as `cfg_n`.
- `cfg_k` in 32: M fractional value.
- `cfg_c0`, `cfg_c1`, `cfg_c2` in 18 each: C counter words, same layout as `cfg_n`.
- `cfg_busy` out 1: high from acceptance until `cfg_done`.
- `cfg_done` out 1: one-cycle pulse at end of sequence, on success or timeout.
- `cfg_err` out 1: sticky timeout flag; cleared when the next `cfg_start` is accepted.
- `mgmt_address` out 6, `mgmt_writedata` out 32, `mgmt_write` out 1, `mgmt_read` out 1: Avalon-MM master port.
- `mgmt_waitrequest` in 1: slave stall.
- `pll_locked` in 1: PLL `locked`, asynchronous.

## Operation
- Inputs are latched into shadow registers on acceptance, so later input changes have no effect.
- States and register writes, in order:
  - IDLE
  - WR_MODE: addr 0, data 0 (waitrequest mode)
  - WR_N: addr 3
  - WR_M: addr 4
  - WR_K: addr 7 (see Configuration)
  - WR_C: addr 5, issued three times with index 0..2
  - WR_START: addr 2, data 1
  - SETTLE
  - WAIT_LOCK
  - DONE → IDLE
- N and M write data: {14'b0, word}.
- C write data: {9'b0, sel[4:0], word}, where sel is 0, 1, 2 for C0..C2.
- SETTLE counts `SETTLE_CYCLES`, then moves to WAIT_LOCK.
- WAIT_LOCK:
  - Synchronized lock high for 4 consecutive cycles → DONE with `cfg_err`=0.
  - Timeout counter, which starts when the start-write completes, reaches `LOCK_TIMEOUT` → DONE with `cfg_err`=1.
- `cfg_start` is ignored while busy; this includes a start arriving in the DONE cycle.
- `mgmt_read` is tied to 0.
- `rst` mid-sequence abandons the sequence. The reconfig IP shares `rst`, so no partial transaction survives.

## Timing
- Reset values: `cfg_busy`, `cfg_done`, `cfg_err`, `mgmt_write`, `mgmt_read` = 0; `mgmt_address`, `mgmt_writedata` = 0; state IDLE; synchronizer flops 0.
- `cfg_start` sampled high in IDLE → `cfg_busy` and `mgmt_write` high on the next cycle, with the WR_MODE address and data.
- A write completes on the edge where `mgmt_write`=1 and `mgmt_waitrequest`=0.
- Address and data are held constant while waitrequest is high.
- The next write is presented in the cycle after completion, with no idle gap.
- `pll_locked` passes through a 2-flop synchronizer, adding 2 cycles of latency.
- `cfg_done` asserts in the same cycle `cfg_busy` falls.
- `cfg_err` updates in the `cfg_done` cycle.
- The timeout counter is $clog2(`LOCK_TIMEOUT`+1) bits wide and saturates; it never wraps.

## Configuration
- `PLL_CFG_FRAC_EN` defined: WR_K is issued (addr 7, data `cfg_k`). Sequence is 8 writes.
- Not defined: WR_K is skipped (WR_M → WR_C). `cfg_k` is unused; the port remains. Sequence is 7 writes.

## Structure
- Package `pll_cfg_pkg` holds:
  - register address constants (mode 0, start 2, N 3, M 4, C 5, K 7)
  - state enum
  - counter-word field offsets and the C-select shift (18)
  - lock stable count (4)
- One sub-module, `pll_cfg_sync`: 2-flop synchronizer for `pll_locked`.

## Test plan
- Reset: `rst` for 3 cycles with random inputs → all outputs 0. `cfg_start` during reset → no write ever issued.
- Nominal, macro on, waitrequest low: `cfg_n`=0x20000, `cfg_m`=0x00808, `cfg_k`=0x80000000, `cfg_c0`/`cfg_c1`/`cfg_c2`=0x00202. Required:
  - 8 consecutive writes: (0,0), (3,0x20000), (4,0x00808), (7,0x80000000), (5,0x00202), (5,0x40202), (5,0x80202), (2,1).
  - Lock raised 20 cycles later → `cfg_done` pulse, `cfg_err`=0.
- Stall: waitrequest high for 3 cycles on every write → each write held for 4 cycles with stable address and data, and no write is duplicated or skipped.
- Timeout: `LOCK_TIMEOUT`=100, lock held low → `cfg_done` and `cfg_err`=1 exactly 100 cycles after start-write completion. `cfg_err` stays 1 until the next `cfg_start`.
- Interference:
  - `cfg_start` pulsed mid-sequence → ignored.
  - Lock glitch of 2 cycles → no completion.
  - `rst` during WR_M → `mgmt_write`=0 and `cfg_busy`=0 next cycle.
- Macro off: nominal stimulus → 7 writes, no address 7.
